// File: rtl/mfrsd_flash_ctrl.sv
// JEDEC byte-mode flash command decoder that emulates program and erase
// operations on a simple request/acknowledge backing memory.
module mfrsd_flash_ctrl #(
    parameter int unsigned ADDR_W   = 23,
    parameter int unsigned SECTOR_W = 16,
    parameter logic [7:0]  MFR_ID   = 8'h01,
    parameter logic [7:0]  DEV_ID   = 8'h7E
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              rd_override,
    output logic [7:0]        rd_data,
    output logic              busy
);

    typedef enum logic [3:0] {
        S_READ, S_U1, S_U2, S_AUTOSEL, S_PROG_ARM, S_PROG_RD, S_PROG_WR,
        S_E_U1, S_E_U2, S_E_U3, S_E_ARM, S_ERASE_RUN
    } state_t;

    state_t              r_state;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic                r_rd_override;
    logic [7:0]          r_rd_data;
    logic                r_toggle;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_chip;
    logic [ADDR_W-1:0]   r_paddr;
    logic [7:0]          r_pdata;

    logic                w_aaa;
    logic                w_555;
    logic                w_busy;
    logic                w_unlock;
    logic                w_last;
    logic [7:0]          w_id;

    assign w_aaa    = (cpu_addr[11:0] == 12'hAAA);
    assign w_555    = (cpu_addr[11:0] == 12'h555);
    assign w_busy   = (r_state == S_PROG_RD) || (r_state == S_PROG_WR) || (r_state == S_ERASE_RUN);
    assign w_unlock = cpu_wr && w_aaa && (cpu_data == 8'hAA);
    assign w_last   = r_chip ? (&r_cnt) : (&r_cnt[SECTOR_W-1:0]);

    always_comb begin
        w_id = 8'h00;
        case (cpu_addr[7:0])
            8'h00:   w_id = MFR_ID;
            8'h02:   w_id = DEV_ID;
            default: w_id = 8'h00;
        endcase
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign rd_override = r_rd_override;
    assign rd_data     = r_rd_data;
    assign busy        = w_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_READ;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_rd_override <= 1'b0;
            r_rd_data     <= 8'hFF;
            r_toggle      <= 1'b0;
            r_cnt         <= '0;
            r_chip        <= 1'b0;
            r_paddr       <= '0;
            r_pdata       <= '0;
        end else begin
            // Read response is registered: it reflects the state seen when cpu_rd was strobed.
            r_toggle      <= w_busy ? (r_toggle ^ cpu_rd) : 1'b0;
            r_rd_override <= w_busy || (r_state == S_AUTOSEL);
            if (w_busy)
                r_rd_data <= {1'b0, r_toggle ^ cpu_rd, 6'b0};
            else if (r_state == S_AUTOSEL)
                r_rd_data <= w_id;
            else
                r_rd_data <= 8'hFF;

            case (r_state)
                S_PROG_RD: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_paddr;
                    end else if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_pdata   <= mem_rdata & r_pdata;
                        r_state   <= S_PROG_WR;
                    end
                end
                S_PROG_WR: begin
                    if (!r_mem_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_paddr;
                        r_mem_wdata <= r_pdata;
                    end else if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= w_unlock ? S_U1 : S_READ;
                    end
                end
                S_E_ARM: begin
                    r_state <= (cpu_wr && cpu_data == 8'hF0) ? S_READ : S_ERASE_RUN;
                end
                S_ERASE_RUN: begin
                    if (!r_mem_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_cnt;
                        r_mem_wdata <= 8'hFF;
                    end else if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (w_last)
                            r_state <= w_unlock ? S_U1 : S_READ;
                        else
                            r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (cpu_wr) begin
                        if (cpu_data == 8'hF0) begin
                            r_state <= S_READ;
                        end else begin
                            case (r_state)
                                S_READ, S_AUTOSEL: if (w_aaa && cpu_data == 8'hAA) r_state <= S_U1;
                                S_U1:   r_state <= (w_555 && cpu_data == 8'h55) ? S_U2 : S_READ;
                                S_U2: begin
                                    if (w_aaa && cpu_data == 8'hA0)      r_state <= S_PROG_ARM;
                                    else if (w_aaa && cpu_data == 8'h90) r_state <= S_AUTOSEL;
                                    else if (w_aaa && cpu_data == 8'h80) r_state <= S_E_U1;
                                    else                                 r_state <= S_READ;
                                end
                                S_E_U1: r_state <= (w_aaa && cpu_data == 8'hAA) ? S_E_U2 : S_READ;
                                S_E_U2: r_state <= (w_555 && cpu_data == 8'h55) ? S_E_U3 : S_READ;
                                S_E_U3: begin
                                    if (w_aaa && cpu_data == 8'h10) begin
                                        r_chip  <= 1'b1;
                                        r_cnt   <= '0;
                                        r_state <= S_E_ARM;
                                    end else if (cpu_data == 8'h30) begin
                                        r_chip  <= 1'b0;
                                        r_cnt   <= {cpu_addr[ADDR_W-1:SECTOR_W], SECTOR_W'(0)};
                                        r_state <= S_E_ARM;
                                    end else begin
                                        r_state <= S_READ;
                                    end
                                end
                                S_PROG_ARM: begin
                                    r_paddr <= cpu_addr;
                                    r_pdata <= cpu_data;
                                    r_state <= S_PROG_RD;
                                end
                                default: r_state <= S_READ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfrsd_flash_ctrl.sv
// Randomized bench for mfrsd_flash_ctrl: a behavioural flash-memory model
// predicts the backing store contents and bus traffic for each command.
module tb_mfrsd_flash_ctrl;

    localparam int unsigned AW    = 13;
    localparam int unsigned SW    = 9;
    localparam int unsigned MSIZE = 1 << AW;
    localparam int unsigned SSIZE = 1 << SW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_wr;
    logic          cpu_rd;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_data;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ack;
    logic [7:0]    mem_rdata;
    logic          rd_override;
    logic [7:0]    rd_data;
    logic          busy;

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;

    logic [7:0]    mem     [MSIZE];
    logic [7:0]    ref_mem [MSIZE];
    bit            resp_en;
    bit            force_ack;
    int unsigned   wr_cnt, rd_cnt, wr_bad;
    logic [AW-1:0] wr_first, wr_last;

    mfrsd_flash_ctrl #(
        .ADDR_W   (AW),
        .SECTOR_W (SW),
        .MFR_ID   (8'h01),
        .DEV_ID   (8'h7E)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_wr      (cpu_wr),
        .cpu_rd      (cpu_rd),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .rd_override (rd_override),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Backing memory: random 1-2 cycle latency, logs every completed access.
    initial begin
        int unsigned wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            mem_ack = force_ack;
            if (!resp_en || reset) begin
                wait_cnt = 0;
            end else if (mem_req) begin
                if (wait_cnt == 0) wait_cnt = $urandom_range(2, 1);
                wait_cnt--;
                if (wait_cnt == 0) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        if (wr_cnt == 0) wr_first = mem_addr;
                        else if (mem_addr != wr_last + 1'b1) wr_bad++;
                        wr_last = mem_addr;
                        wr_cnt++;
                    end else begin
                        mem_rdata = mem[mem_addr];
                        rd_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom);
    endfunction

    function automatic logic [AW-1:0] cmd_a(input logic [11:0] lo);
        logic [AW-1:0] a;
        a = AW'($urandom);
        a[11:0] = lo;
        return a;
    endfunction

    function automatic int unsigned mem_diffs();
        int unsigned n = 0;
        for (int unsigned i = 0; i < MSIZE; i++)
            if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic fill_mem();
        for (int unsigned i = 0; i < MSIZE; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
    endtask

    task automatic clear_log();
        wr_cnt = 0;
        rd_cnt = 0;
        wr_bad = 0;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_wr   = 1'b1;
        @(posedge clk); #1;
        cpu_wr   = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, output logic [7:0] d, output logic ovr);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        @(posedge clk); #1;
        cpu_rd   = 1'b0;
        d        = rd_data;
        ovr      = rd_override;
    endtask

    task automatic unlock();
        cpu_write(cmd_a(12'hAAA), 8'hAA);
        cpu_write(cmd_a(12'h555), 8'h55);
    endtask

    task automatic wait_busy(input logic want, input int unsigned budget, input string tag);
        for (int unsigned i = 0; i < budget && busy !== want; i++) begin
            @(posedge clk); #1;
        end
        check(tag, 32'(busy), 32'(want));
    endtask

    task automatic do_program(input logic [AW-1:0] a, input logic [7:0] d, input string tag);
        clear_log();
        unlock();
        cpu_write(cmd_a(12'hAAA), 8'hA0);
        cpu_write(a, d);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_busy(1'b0, 50, {tag, "_done"});
        ref_mem[a] = ref_mem[a] & d;
        check({tag, "_data"}, 32'(mem[a]), 32'(ref_mem[a]));
        check({tag, "_rdcnt"}, rd_cnt, 32'd1);
        check({tag, "_wrcnt"}, wr_cnt, 32'd1);
        check({tag, "_wraddr"}, 32'(wr_last), 32'(a));
        check({tag, "_req"}, 32'(mem_req), 32'd0);
    endtask

    task automatic do_erase(input bit chip, input logic [AW-1:0] a30, input bit status_test, input string tag);
        logic [AW-1:0] base;
        int unsigned   n;
        logic [7:0]    d;
        logic          o;
        clear_log();
        unlock();
        cpu_write(cmd_a(12'hAAA), 8'h80);
        unlock();
        if (chip) cpu_write(cmd_a(12'hAAA), 8'h10);
        else      cpu_write(a30, 8'h30);
        base = chip ? '0 : ((a30 >> SW) << SW);
        n    = chip ? MSIZE : SSIZE;
        wait_busy(1'b1, 10, {tag, "_busy"});
        if (status_test) begin
            cpu_read(rand_addr(), d, o);
            check({tag, "_st1"}, 32'(d), 32'h40);
            check({tag, "_ovr"}, 32'(o), 32'd1);
            cpu_read(rand_addr(), d, o);
            check({tag, "_st2"}, 32'(d), 32'h00);
            cpu_read(rand_addr(), d, o);
            check({tag, "_st3"}, 32'(d), 32'h40);
            cpu_write(cmd_a(12'hAAA), 8'hAA);
            check({tag, "_ignAA"}, 32'(busy), 32'd1);
            cpu_write(rand_addr(), 8'hF0);
            check({tag, "_ignF0"}, 32'(busy), 32'd1);
        end
        wait_busy(1'b0, n * 4 + 50, {tag, "_done"});
        for (int unsigned i = 0; i < n; i++) ref_mem[base + AW'(i)] = 8'hFF;
        check({tag, "_wrcnt"}, wr_cnt, n);
        check({tag, "_first"}, 32'(wr_first), 32'(base));
        check({tag, "_last"}, 32'(wr_last), 32'(base + AW'(n - 1)));
        check({tag, "_order"}, wr_bad, 32'd0);
        check({tag, "_rdcnt"}, rd_cnt, 32'd0);
        check({tag, "_mem"}, mem_diffs(), 32'd0);
        if (status_test) begin
            cpu_write(cmd_a(12'h555), 8'h55);
            cpu_write(cmd_a(12'hAAA), 8'h90);
            cpu_read(rand_addr(), d, o);
            check({tag, "_after_ovr"}, 32'(o), 32'd0);
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic          o;
        int unsigned   n;

        reset     = 1'b1;
        cpu_wr    = 1'b0;
        cpu_rd    = 1'b0;
        cpu_addr  = '0;
        cpu_data  = '0;
        resp_en   = 1'b1;
        force_ack = 1'b0;
        clear_log();
        fill_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(rd_override), 32'd0);
        check("rst_rdata", 32'(rd_data), 32'hFF);
        reset = 1'b0;
        @(posedge clk); #1;

        cpu_read(rand_addr(), d, o);
        check("idle_rd_ovr", 32'(o), 32'd0);
        check("idle_rd_data", 32'(d), 32'hFF);

        // Program with bits that may only clear: F0 & 3C = 30
        a = AW'(32'h012345);
        mem[a] = 8'hF0;
        ref_mem[a] = 8'hF0;
        do_program(a, 8'h3C, "prog_fixed");
        check("prog_fixed_val", 32'(mem[a]), 32'h30);

        // Autoselect
        unlock();
        cpu_write(cmd_a(12'hAAA), 8'h90);
        a = rand_addr(); a[7:0] = 8'h00;
        cpu_read(a, d, o);
        check("asel_ovr", 32'(o), 32'd1);
        check("asel_mfr", 32'(d), 32'h01);
        a = rand_addr(); a[7:0] = 8'h02;
        cpu_read(a, d, o);
        check("asel_dev", 32'(d), 32'h7E);
        a = rand_addr(); a[7:0] = 8'h04;
        cpu_read(a, d, o);
        check("asel_other", 32'(d), 32'h00);
        cpu_write(rand_addr(), 8'h55);
        a = rand_addr(); a[7:0] = 8'h00;
        cpu_read(a, d, o);
        check("asel_ignore", 32'(d), 32'h01);
        cpu_write(rand_addr(), 8'hF0);
        cpu_read(a, d, o);
        check("asel_exit_ovr", 32'(o), 32'd0);
        check("asel_exit_data", 32'(d), 32'hFF);

        // Bad unlock sequence must not reach memory
        clear_log();
        cpu_write(cmd_a(12'hAAA), 8'hAA);
        cpu_write(cmd_a(12'h555), 8'h56);
        cpu_write(cmd_a(12'hAAA), 8'hA0);
        cpu_write(AW'(0), 8'h12);
        repeat (10) @(posedge clk);
        #1;
        check("bad_seq_acc", rd_cnt + wr_cnt, 32'd0);
        check("bad_seq_busy", 32'(busy), 32'd0);

        // Sector erases, one with status polling and ignored writes
        a = rand_addr();
        do_erase(1'b0, a, 1'b1, "sec_erase_st");
        fill_mem();
        do_erase(1'b0, rand_addr(), 1'b0, "sec_erase");

        // Stray acknowledge while idle
        clear_log();
        #2 force_ack = 1'b1;
        @(posedge clk); #2 force_ack = 1'b0;
        @(posedge clk); #1;
        check("stray_ack_busy", 32'(busy), 32'd0);
        check("stray_ack_req", 32'(mem_req), 32'd0);

        // Chip erase
        fill_mem();
        do_erase(1'b1, '0, 1'b0, "chip_erase");

        // Randomized programs and broken sequences
        for (int unsigned it = 0; it < 12; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                do_program(rand_addr(), 8'($urandom), "prog_rand");
            end else begin
                clear_log();
                d = 8'($urandom);
                if (d == 8'h55) d = 8'h54;
                cpu_write(cmd_a(12'hAAA), 8'hAA);
                cpu_write(cmd_a(12'h555), d);
                cpu_write(cmd_a(12'hAAA), 8'hA0);
                cpu_write(rand_addr(), 8'($urandom));
                repeat (6) @(posedge clk);
                #1;
                check("bad_rand_acc", rd_cnt + wr_cnt, 32'd0);
                check("bad_rand_busy", 32'(busy), 32'd0);
            end
        end
        check("rand_mem", mem_diffs(), 32'd0);

        // Reset in the middle of a chip erase
        fill_mem();
        clear_log();
        unlock();
        cpu_write(cmd_a(12'hAAA), 8'h80);
        unlock();
        cpu_write(cmd_a(12'hAAA), 8'h10);
        wait_busy(1'b1, 10, "rst_mid_busy");
        for (int unsigned i = 0; i < 400 && !(mem_req === 1'b1 && wr_cnt >= 5); i++) begin
            @(posedge clk); #1;
        end
        check("rst_mid_req_before", 32'(mem_req), 32'd1);
        resp_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_busy_now", 32'(busy), 32'd0);
        check("rst_mid_rdata", 32'(rd_data), 32'hFF);
        n = wr_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #2 force_ack = 1'b1;
        @(posedge clk); #2 force_ack = 1'b0;
        @(posedge clk); #1;
        resp_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_mid_nowr", wr_cnt, n);
        check("rst_mid_req_after", 32'(mem_req), 32'd0);
        check("rst_mid_busy_after", 32'(busy), 32'd0);
        for (int unsigned i = 0; i < n; i++) ref_mem[i] = 8'hFF;
        check("rst_mid_partial", mem_diffs(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
